perfcounter_sched: RTL and testbench
====================================

# perfcounter_sched

Windowed scheduler for the performance-counter bank. It gates a set of per-cycle event strobes into saturating counters and closes a sampling window at a programmed interval. At each window close it snapshots every counter into a shadow bank and clears the live counters without losing a cycle. Host logic reads the snapshot through an indexed, registered read port and releases it with an acknowledge pulse. The block sits between the event sources in the SoC and the CSR front end, inside the `sim_bench` perfcounter harness.

## Interface
- `NUM_EVENTS`, 8, number of event channels (2..16)
- `CNT_W`, 32, live/shadow counter width
- `PRE_W`, 16, prescaler width
- `PER_W`, 16, window-period width
- `clk` in 1 system clock
- `rst` in 1 reset; asynchronous, active-high
- `cfg_enable` in 1 run request (level)
- `cfg_prescale` in PRE_W ticks every cfg_prescale+1 cycles
- `cfg_period` in PER_W window = cfg_period+1 ticks
- `cfg_mask` in NUM_EVENTS per-channel count enable
- `event_in` in NUM_EVENTS one count per cycle high, per channel
- `rd_sel` in clog2(NUM_EVENTS) shadow index
- `rd_data` out CNT_W shadow[rd_sel], registered
- `snap_valid` out 1 shadow holds an unacknowledged snapshot
- `snap_ack` in 1 single-cycle release of the snapshot
- `window_id` out 16 count of completed windows, wraps
- `overrun` out 1 sticky; a window closed while snap_valid=1
- `running` out 1 FSM in RUN

## Operation
- FSM states: IDLE, START, RUN.
  - IDLE→START when cfg_enable=1.
  - START (1 cycle): clear live counters, prescaler, tick counter, window_id, overrun → RUN.
  - RUN→IDLE when cfg_enable=0; live counters hold, shadow and snap_valid untouched.
- Config is sampled continuously. Changes take effect at the next window boundary or the next START; host changes config only in IDLE.
- Counting (RUN only): live[i] += 1 when event_in[i] & cfg_mask[i]; saturates at 2^CNT_W−1 and does not wrap.
- Prescaler counts 0..cfg_prescale and emits a tick on terminal count. The tick counter counts ticks 0..cfg_period.
- Window close occurs on the cycle with tick and tick-count == cfg_period, so the window is (cfg_prescale+1)·(cfg_period+1) cycles.
- On the close cycle:
  - If snap_valid=0: shadow[i] ← live[i] plus that cycle's event (saturated).
  - If snap_valid=1: shadow is kept, overrun ← 1.
  - In both cases: live counters ← 0, snap_valid ← 1, window_id += 1.
- An event on the close cycle belongs to the closing window. An event on the next cycle belongs to the new window. No cycle is lost.
- snap_ack clears snap_valid. If ack and close occur in the same cycle, the close wins: shadow is updated, snap_valid stays 1, overrun is not set.
- overrun clears only on START or rst.
- snap_ack while snap_valid=0 is ignored.

## Timing
- Reset values: all outputs 0, FSM IDLE, all counters and shadow 0.
- cfg_enable rise at cycle t gives START at t+1 and the first RUN cycle at t+2. Counting starts at t+2.
- snap_valid, window_id and overrun update the cycle after the close cycle.
- rd_data = shadow[rd_sel] one cycle after rd_sel is presented; it reflects a shadow update one cycle after snap_valid rises.
- rd_sel ≥ NUM_EVENTS gives rd_data = 0.
- rst mid-window aborts asynchronously; nothing is retained.

## Structure
- Shared package `perfcounter_pkg`:
  - FSM state enum `pc_state_t`
  - localparam `SEL_W = $clog2(NUM_EVENTS)`
  - saturating-increment function
- Sub-module `perfcounter_sched_tick`: prescaler plus tick counter, emitting `tick` and `window_close`.
- Counter bank and shadow are generated per channel in the top.

## Test plan
- Basic window: prescale=0, period=9, mask=0x01, event_in[0]=1 constant, enable. The first snap_valid rises 11 cycles after the first RUN cycle; shadow[0]=10, window_id=1; rd_sel=0 gives rd_data=10 one cycle later.
- Prescaled masking: prescale=3, period=4 (20 cycles), mask=0x05, all events toggling every cycle from the first RUN cycle. Expect shadow[0]=shadow[2]=10 and shadow[1]=0.
- Overrun: period=4, prescale=0, never ack for two closes. Overrun=1 after the second close, shadow retains window-1 values, window_id=2. Disable/enable clears overrun.
- Ack/close collision: snap_ack asserted on exactly the close cycle. snap_valid stays 1, shadow holds the new window, overrun=0.
- Saturation: CNT_W=4, period=31, event constant. shadow=15 and no wrap.
- Async reset mid-window (cycle 5 of 10): all outputs 0 immediately; re-enable gives a fresh 10-count window.

Source files
------------

// File: rtl/perfcounter_pkg.sv
// Shared types and helpers for the windowed performance-counter scheduler.
package perfcounter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } pc_state_t;

    // Default channel count and the read-index width that goes with it.
    localparam int PC_NUM_EVENTS = 8;
    localparam int SEL_W         = $clog2(PC_NUM_EVENTS);

    // Widest counter the saturating helper supports.
    localparam int PC_SAT_W = 64;

    // Increment v by one, holding at the all-ones value of a w-bit counter.
    function automatic logic [PC_SAT_W-1:0] pc_sat_inc(input logic [PC_SAT_W-1:0] v,
                                                        input int unsigned         w);
        logic [PC_SAT_W-1:0] max_v;
        if (w >= PC_SAT_W) max_v = '1;
        else               max_v = (PC_SAT_W'(1) << w) - PC_SAT_W'(1);
        return (v >= max_v) ? max_v : v + PC_SAT_W'(1);
    endfunction

endpackage

// File: rtl/perfcounter_sched_tick.sv
// Prescaler and tick counter: emits a tick every cfg_prescale+1 running cycles
// and flags the tick that completes a cfg_period+1 tick window.
module perfcounter_sched_tick #(
    parameter int PRE_W = 16,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic [PER_W-1:0] cfg_period,
    output logic             tick,
    output logic             window_close
);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PER_W-1:0] tcnt_q, tcnt_d;

    // >= rather than == so a counter left above a shrunken limit still wraps promptly.
    assign tick         = run & (pre_q >= cfg_prescale);
    assign window_close = tick & (tcnt_q >= cfg_period);

    // Next-state for the prescaler and tick counter.
    always_comb begin
        pre_d  = pre_q;
        tcnt_d = tcnt_q;
        if (clear) begin
            pre_d  = '0;
            tcnt_d = '0;
        end else if (run) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
            if (tick) tcnt_d = window_close ? '0 : tcnt_q + PER_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            tcnt_q <= '0;
        end else begin
            pre_q  <= pre_d;
            tcnt_q <= tcnt_d;
        end
    end

endmodule

// File: rtl/perfcounter_sched.sv
// Windowed performance-counter scheduler: gated saturating live counters,
// periodic snapshot into a shadow bank, registered indexed read port.
//
// state | meaning
// IDLE  | stopped; live counters and shadow hold
// START | one cycle: clear live counters, timers, window_id, overrun
// RUN   | counting events, closing windows on the tick schedule
module perfcounter_sched
    import perfcounter_pkg::*;
#(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_W      = 32,
    parameter int PRE_W      = 16,
    parameter int PER_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_enable,
    input  logic [PRE_W-1:0]              cfg_prescale,
    input  logic [PER_W-1:0]              cfg_period,
    input  logic [NUM_EVENTS-1:0]         cfg_mask,
    input  logic [NUM_EVENTS-1:0]         event_in,
    input  logic [$clog2(NUM_EVENTS)-1:0] rd_sel,
    output logic [CNT_W-1:0]              rd_data,
    output logic                          snap_valid,
    input  logic                          snap_ack,
    output logic [15:0]                   window_id,
    output logic                          overrun,
    output logic                          running
);

    pc_state_t        state_q, state_d;
    logic             running_q;
    logic             snap_valid_q, snap_valid_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      window_id_q, window_id_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic             in_start, in_run;
    logic             tick_w, win_close_w, close;
    logic             shadow_load;
    logic [CNT_W-1:0] shadow_arr [NUM_EVENTS];

    assign in_start = (state_q == START);
    assign in_run   = (state_q == RUN);

    // Next-state logic for the run-control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_enable)  state_d = START;
            START:                    state_d = RUN;
            RUN:     if (!cfg_enable) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // FSM register with its registered running flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
        end
    end

    perfcounter_sched_tick #(
        .PRE_W (PRE_W),
        .PER_W (PER_W)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .clear        (in_start),
        .run          (in_run),
        .cfg_prescale (cfg_prescale),
        .cfg_period   (cfg_period),
        .tick         (tick_w),
        .window_close (win_close_w)
    );

    // A close is only ever qualified by a tick; keep both terms explicit.
    assign close = tick_w & win_close_w;

    // An ack landing on the close cycle frees the shadow for the closing window.
    assign shadow_load = ~snap_valid_q | snap_ack;

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_ch
        logic [CNT_W-1:0] live_q, live_d, live_inc;
        logic [CNT_W-1:0] shadow_q, shadow_d;

        // Live counter and shadow next-state; the close-cycle event lands in the snapshot.
        always_comb begin
            live_inc = (event_in[g] & cfg_mask[g])
                     ? CNT_W'(pc_sat_inc(PC_SAT_W'(live_q), CNT_W))
                     : live_q;
            live_d   = live_q;
            shadow_d = shadow_q;
            if (in_start) begin
                live_d = '0;
            end else if (in_run) begin
                if (close) begin
                    live_d = '0;
                    if (shadow_load) shadow_d = live_inc;
                end else begin
                    live_d = live_inc;
                end
            end
        end

        // Per-channel live and shadow registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                live_q   <= '0;
                shadow_q <= '0;
            end else begin
                live_q   <= live_d;
                shadow_q <= shadow_d;
            end
        end

        assign shadow_arr[g] = shadow_q;
    end

    // Snapshot handshake, window numbering and overrun tracking.
    always_comb begin
        snap_valid_d = snap_valid_q;
        if (close)         snap_valid_d = 1'b1;
        else if (snap_ack) snap_valid_d = 1'b0;

        overrun_d = overrun_q;
        if (in_start)                                  overrun_d = 1'b0;
        else if (close && snap_valid_q && !snap_ack)   overrun_d = 1'b1;

        window_id_d = window_id_q;
        if (in_start)   window_id_d = '0;
        else if (close) window_id_d = window_id_q + 16'd1;

        rd_data_d = '0;
        if (32'(rd_sel) < NUM_EVENTS) rd_data_d = shadow_arr[rd_sel];
    end

    // Status and read-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            window_id_q  <= '0;
            rd_data_q    <= '0;
        end else begin
            snap_valid_q <= snap_valid_d;
            overrun_q    <= overrun_d;
            window_id_q  <= window_id_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign snap_valid = snap_valid_q;
    assign overrun    = overrun_q;
    assign window_id  = window_id_q;
    assign running    = running_q;

endmodule

// File: tb/tb_perfcounter_sched.sv
// Bench for perfcounter_sched: window-level behavioural model compared every
// cycle, plus hand-computed checks for each scenario.
`timescale 1ns/1ps
module tb_perfcounter_sched;
    import perfcounter_pkg::*;

    localparam int NE = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b0;
    logic             cfg_enable = 1'b0;
    logic [15:0]      cfg_prescale = '0;
    logic [15:0]      cfg_period = '0;
    logic [NE-1:0]    cfg_mask = '0;
    logic [NE-1:0]    event_in = '0;
    logic [SEL_W-1:0] rd_sel = '0;
    logic             snap_ack = 1'b0;
    logic [31:0]      rd_data;
    logic             snap_valid;
    logic [15:0]      window_id;
    logic             overrun;
    logic             running;

    logic             s_enable = 1'b0;
    logic [NE-1:0]    s_event = '0;
    logic [3:0]       s_rd_data;
    logic             s_snap_valid;
    logic [15:0]      s_window_id;
    logic             s_overrun;
    logic             s_running;

    int n_cmp = 0;
    int n_err = 0;

    perfcounter_sched #(.NUM_EVENTS(NE), .CNT_W(32), .PRE_W(16), .PER_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_prescale(cfg_prescale),
        .cfg_period(cfg_period), .cfg_mask(cfg_mask), .event_in(event_in), .rd_sel(rd_sel),
        .rd_data(rd_data), .snap_valid(snap_valid), .snap_ack(snap_ack),
        .window_id(window_id), .overrun(overrun), .running(running)
    );

    perfcounter_sched #(.NUM_EVENTS(NE), .CNT_W(4), .PRE_W(16), .PER_W(16)) dut_sat (
        .clk(clk), .rst(rst), .cfg_enable(s_enable), .cfg_prescale(16'd0),
        .cfg_period(16'd31), .cfg_mask(8'h01), .event_in(s_event), .rd_sel('0),
        .rd_data(s_rd_data), .snap_valid(s_snap_valid), .snap_ack(1'b0),
        .window_id(s_window_id), .overrun(s_overrun), .running(s_running)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (main instance) ----------------
    // Windows are counted in RUN cycles since START: a window ends on every
    // RUN cycle whose 1-based index is a multiple of (prescale+1)*(period+1).
    localparam longint MAX32 = 64'hFFFF_FFFF;
    int     m_mode = 0;          // 0 stopped, 1 start cycle, 2 running
    longint m_k = 0;
    bit     m_run = 0, m_sv = 0, m_ovr = 0;
    int     m_wid = 0;
    longint m_rd = 0;
    longint m_live [NE];
    longint m_shadow [NE];

    always @(posedge clk or posedge rst) begin : model
        longint rd_n, nv;
        longint len;
        bit     cl;
        if (rst) begin
            m_mode = 0; m_k = 0; m_run = 0; m_sv = 0; m_ovr = 0; m_wid = 0; m_rd = 0;
            for (int i = 0; i < NE; i++) begin m_live[i] = 0; m_shadow[i] = 0; end
        end else begin
            rd_n = (int'(rd_sel) < NE) ? m_shadow[rd_sel] : 0;
            cl = 0;
            case (m_mode)
                0: if (cfg_enable) m_mode = 1;
                1: begin
                    for (int i = 0; i < NE; i++) m_live[i] = 0;
                    m_k = 0; m_wid = 0; m_ovr = 0; m_mode = 2;
                end
                default: begin
                    len = (longint'(cfg_prescale) + 1) * (longint'(cfg_period) + 1);
                    cl  = ((m_k + 1) % len) == 0;
                    m_k++;
                    for (int i = 0; i < NE; i++) begin
                        nv = m_live[i] + ((event_in[i] && cfg_mask[i]) ? 1 : 0);
                        if (nv > MAX32) nv = MAX32;
                        if (cl) begin
                            if (!m_sv || snap_ack) m_shadow[i] = nv;
                            m_live[i] = 0;
                        end else begin
                            m_live[i] = nv;
                        end
                    end
                    if (cl) begin
                        if (m_sv && !snap_ack) m_ovr = 1;
                        m_wid = (m_wid + 1) & 16'hFFFF;
                    end
                    if (!cfg_enable) m_mode = 0;
                end
            endcase
            if (cl)            m_sv = 1;
            else if (snap_ack) m_sv = 0;
            m_run = (m_mode == 2);
            m_rd  = rd_n;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("running",    running,    m_run);
        check("snap_valid", snap_valid, m_sv);
        check("window_id",  window_id,  m_wid);
        check("overrun",    overrun,    m_ovr);
        check("rd_data",    rd_data,    m_rd);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_running(input logic val, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (running === val) break;
        end
        check(name, (running === val) ? 1 : 0, 1);
    endtask

    // Returns the 1-based RUN-cycle number on which snap_valid is first seen,
    // counting the current (first RUN) cycle as 1.
    task automatic cycles_to_snap(input int budget, output int n);
        n = 1;
        while (snap_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic read_chk(input int sel, input longint exp, input string name);
        rd_sel = SEL_W'(sel);
        @(posedge clk);
        @(negedge clk);
        check(name, rd_data, exp);
    endtask

    task automatic pulse_ack();
        snap_ack = 1'b1;
        @(negedge clk);
        snap_ack = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_running", running, 0);
        check("rst_snap_valid", snap_valid, 0);
        check("rst_window_id", window_id, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_data", rd_data, 0);

        // Basic window: 10-cycle window, channel 0 always firing.
        cfg_prescale = 16'd0; cfg_period = 16'd9; cfg_mask = 8'h01; event_in = 8'h01;
        rd_sel = '0; cfg_enable = 1'b1;
        wait_running(1'b1, 10, "t1_start");
        cycles_to_snap(40, n);
        check("t1_snap_cycle", n, 11);        // close on RUN cycle 10, visible on 11
        check("t1_window_id", window_id, 1);
        check("t1_rd_old", rd_data, 0);
        @(negedge clk);
        check("t1_rd_data", rd_data, 10);
        pulse_ack();
        check("t1_ack", snap_valid, 0);
        cfg_enable = 1'b0;
        wait_running(1'b0, 10, "t1_stop");

        // Prescaled window of 20 cycles, mask 0x05, events alternating.
        cfg_prescale = 16'd3; cfg_period = 16'd4; cfg_mask = 8'h05; event_in = 8'h00;
        cfg_enable = 1'b1;
        wait_running(1'b1, 10, "t2_start");
        for (int j = 0; j < 20; j++) begin
            event_in = (j % 2 == 0) ? 8'hFF : 8'h00;
            @(negedge clk);
        end
        event_in = 8'h00;
        check("t2_snap", snap_valid, 1);
        read_chk(0, 10, "t2_sh0");
        read_chk(1, 0,  "t2_sh1");
        read_chk(2, 10, "t2_sh2");
        read_chk(3, 0,  "t2_sh3");
        pulse_ack();
        cfg_enable = 1'b0;
        wait_running(1'b0, 10, "t2_stop");

        // Overrun: two 5-cycle windows with no ack.
        rd_sel = '0;
        cfg_prescale = 16'd0; cfg_period = 16'd4; cfg_mask = 8'h01; event_in = 8'h01;
        cfg_enable = 1'b1;
        wait_running(1'b1, 10, "t3_start");
        n = 0;
        while (window_id != 16'd2 && n < 30) begin @(negedge clk); n++; end
        check("t3_window_id", window_id, 2);
        check("t3_overrun", overrun, 1);
        check("t3_snap_valid", snap_valid, 1);
        read_chk(0, 5, "t3_shadow_kept");
        cfg_enable = 1'b0;
        wait_running(1'b0, 10, "t3_stop");
        cfg_mask = 8'h03; event_in = 8'h02;
        cfg_enable = 1'b1;
        wait_running(1'b1, 10, "t3_restart");
        check("t3_overrun_cleared", overrun, 0);
        check("t3_wid_cleared", window_id, 0);
        check("t3_snap_kept", snap_valid, 1);

        // Ack on the exact close cycle (RUN cycle 5 of a 5-cycle window).
        repeat (4) @(negedge clk);
        snap_ack = 1'b1;
        @(negedge clk);
        snap_ack = 1'b0;
        check("t4_snap_valid", snap_valid, 1);
        check("t4_overrun", overrun, 0);
        check("t4_window_id", window_id, 1);
        read_chk(1, 5, "t4_shadow_new1");
        read_chk(0, 0, "t4_shadow_new0");
        cfg_enable = 1'b0;
        wait_running(1'b0, 10, "t4_stop");
        pulse_ack();
        check("t4_ack", snap_valid, 0);

        // Asynchronous reset on RUN cycle 5 of a 10-cycle window.
        rd_sel = '0;
        cfg_prescale = 16'd0; cfg_period = 16'd9; cfg_mask = 8'h01; event_in = 8'h01;
        cfg_enable = 1'b1;
        wait_running(1'b1, 10, "t5_start");
        repeat (4) @(negedge clk);
        check("t5_pre_wid_nonzero", (window_id != 0) ? 1 : 0, 0);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_running", running, 0);
        check("t5_rst_snap_valid", snap_valid, 0);
        check("t5_rst_window_id", window_id, 0);
        check("t5_rst_overrun", overrun, 0);
        check("t5_rst_rd_data", rd_data, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        wait_running(1'b1, 10, "t5_restart");
        cycles_to_snap(40, n);
        check("t5_snap_cycle", n, 11);
        check("t5_window_id", window_id, 1);
        @(negedge clk);
        check("t5_rd_data", rd_data, 10);
        cfg_enable = 1'b0;
        wait_running(1'b0, 10, "t5_stop");
        pulse_ack();

        // Saturation on the 4-bit instance: 32 events into a counter that tops at 15.
        s_event = 8'h01;
        s_enable = 1'b1;
        n = 0;
        while (s_snap_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("t6_snap_valid", s_snap_valid, 1);
        check("t6_window_id", s_window_id, 1);
        check("t6_overrun", s_overrun, 0);
        @(negedge clk);
        check("t6_saturated", s_rd_data, 15);
        s_enable = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
